// File: rtl/servant_trace_pkg.sv
// Shared state encodings and constant helpers for the servant PC trace block.
package servant_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/servant_pc_trace_if.sv
// Capture tap, control, read-back and status signals of the PC trace block.
interface servant_pc_trace_if #(
  parameter int unsigned AW    = 32,
  parameter int unsigned DEPTH = 64
);
  localparam int unsigned IW = servant_trace_pkg::clog2(DEPTH);

  logic [AW-1:0] i_pc_adr;
  logic          i_pc_vld;
  logic          i_arm;
  logic          i_trig_en;
  logic [AW-1:0] i_trig_adr;
  logic [IW-1:0] i_rd_idx;
  logic          i_rd_en;
  logic [AW-1:0] o_rd_dat;
  logic          o_rd_vld;
  logic [1:0]    o_state;
  logic [IW:0]   o_count;
  logic [IW-1:0] o_trig_idx;
  logic          o_done;

  modport master (
    output i_pc_adr, i_pc_vld, i_arm, i_trig_en, i_trig_adr, i_rd_idx, i_rd_en,
    input  o_rd_dat, o_rd_vld, o_state, o_count, o_trig_idx, o_done
  );

  modport slave (
    input  i_pc_adr, i_pc_vld, i_arm, i_trig_en, i_trig_adr, i_rd_idx, i_rd_en,
    output o_rd_dat, o_rd_vld, o_state, o_count, o_trig_idx, o_done
  );

endinterface

// File: rtl/servant_trace_ram.sv
// DEPTH x AW simple dual-port RAM; registered read returns old data on a same-cycle write.
module servant_trace_ram #(
  parameter  int unsigned AW    = 32,
  parameter  int unsigned DEPTH = 64,
  localparam int unsigned IW    = servant_trace_pkg::clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [AW-1:0] wdat,
  input  logic          re,
  input  logic [IW-1:0] raddr,
  output logic [AW-1:0] rdat
);

  logic [AW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdat <= '0;
    end else if (re) begin
      rdat <= mem[raddr];
    end
  end

endmodule

// File: rtl/servant_pc_trace.sv
// Program-counter trace capture: arm, trigger on address match, record POST samples, freeze.
// Optional SERVANT_TRACE_DEDUP_EN drops samples repeating the last accepted address.
module servant_pc_trace
  import servant_trace_pkg::*;
#(
  parameter int unsigned AW    = 32,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned POST  = 16
) (
  input logic               wb_clk,
  input logic               wb_rst,
  servant_pc_trace_if.slave bus
);

  localparam int unsigned   IW        = clog2(DEPTH);
  localparam logic [IW:0]   COUNT_MAX = (IW+1)'(DEPTH);
  localparam logic [IW-1:0] POST_INIT = IW'(POST);

  trace_state_e  state_q;
  logic [IW-1:0] wr_ptr_q, trig_ptr_q, post_cnt_q;
  logic [IW:0]   count_q;
  logic          wrapped_q, rd_vld_q;
  logic          capturing, fresh, accept, match;
  logic [IW-1:0] rd_base, rd_phys;

  assign capturing = (state_q == ST_ARMED) || (state_q == ST_POST);
  assign accept    = capturing && bus.i_pc_vld && !bus.i_arm && fresh;
  assign match     = (state_q == ST_ARMED) && bus.i_trig_en && (bus.i_pc_adr == bus.i_trig_adr);

`ifdef SERVANT_TRACE_DEDUP_EN
  logic [AW-1:0] last_adr_q;
  logic          last_vld_q;

  assign fresh = !last_vld_q || (bus.i_pc_adr != last_adr_q);

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      last_adr_q <= '0;
      last_vld_q <= 1'b0;
    end else if (bus.i_arm) begin
      last_vld_q <= 1'b0;
    end else if (accept) begin
      last_adr_q <= bus.i_pc_adr;
      last_vld_q <= 1'b1;
    end
  end
`else
  assign fresh = 1'b1;
`endif

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      wrapped_q  <= 1'b0;
      post_cnt_q <= '0;
      trig_ptr_q <= '0;
      rd_vld_q   <= 1'b0;
    end else begin
      rd_vld_q <= bus.i_rd_en;
      if (bus.i_arm) begin
        // Restart from any state; a sample in this cycle is dropped.
        state_q   <= ST_ARMED;
        wr_ptr_q  <= '0;
        count_q   <= '0;
        wrapped_q <= 1'b0;
      end else if (accept) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        if (wr_ptr_q == IW'(DEPTH - 1)) wrapped_q <= 1'b1;
        if (count_q != COUNT_MAX) count_q <= count_q + 1'b1;
        if (match) begin
          trig_ptr_q <= wr_ptr_q;
          post_cnt_q <= POST_INIT;
          state_q    <= (POST == 0) ? ST_DONE : ST_POST;
        end else if (state_q == ST_POST) begin
          post_cnt_q <= post_cnt_q - 1'b1;
          if (post_cnt_q == IW'(1)) state_q <= ST_DONE;
        end
      end
    end
  end

  // Logical index 0 is the oldest entry once the buffer has wrapped.
  assign rd_base = wrapped_q ? wr_ptr_q : '0;
  assign rd_phys = rd_base + bus.i_rd_idx;

  servant_trace_ram #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (wb_clk),
    .rst   (wb_rst),
    .we    (accept),
    .waddr (wr_ptr_q),
    .wdat  (bus.i_pc_adr),
    .re    (bus.i_rd_en),
    .raddr (rd_phys),
    .rdat  (bus.o_rd_dat)
  );

  assign bus.o_rd_vld   = rd_vld_q;
  assign bus.o_state    = state_q;
  assign bus.o_count    = count_q;
  assign bus.o_trig_idx = trig_ptr_q - rd_base;
  assign bus.o_done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_servant_pc_trace.sv
// Bench for servant_pc_trace: two DEPTH=8 instances (POST=2 and POST=0) driven in lockstep,
// checked every cycle against a sample-history model plus directed literal expectations.
module tb_servant_pc_trace;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, arm, vld, trig_en, rd_en;
  logic [31:0] adr, trig_adr;
  logic [2:0]  rd_idx;

  servant_pc_trace_if #(.AW(32), .DEPTH(8)) bus_a ();
  servant_pc_trace_if #(.AW(32), .DEPTH(8)) bus_b ();

  assign bus_a.i_pc_adr   = adr;
  assign bus_a.i_pc_vld   = vld;
  assign bus_a.i_arm      = arm;
  assign bus_a.i_trig_en  = trig_en;
  assign bus_a.i_trig_adr = trig_adr;
  assign bus_a.i_rd_idx   = rd_idx;
  assign bus_a.i_rd_en    = rd_en;
  assign bus_b.i_pc_adr   = adr;
  assign bus_b.i_pc_vld   = vld;
  assign bus_b.i_arm      = arm;
  assign bus_b.i_trig_en  = trig_en;
  assign bus_b.i_trig_adr = trig_adr;
  assign bus_b.i_rd_idx   = rd_idx;
  assign bus_b.i_rd_en    = rd_en;

  servant_pc_trace #(.AW(32), .DEPTH(8), .POST(2)) u_dut_a (
    .wb_clk (clk),
    .wb_rst (rst),
    .bus    (bus_a.slave)
  );

  servant_pc_trace #(.AW(32), .DEPTH(8), .POST(0)) u_dut_b (
    .wb_clk (clk),
    .wb_rst (rst),
    .bus    (bus_b.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  // Model: full list of accepted samples since the last arm; the buffer shows the last 8.
  logic [31:0] hist [2][4096];
  int          m_len   [2];
  int          m_state [2];
  int          m_trig  [2];
  int          m_rem   [2];
  logic [31:0] m_last  [2];
  bit          m_lvld  [2];
  bit          p_rd    [2];
  bit          p_ok    [2];
  logic [31:0] p_dat   [2];
  int          post_of [2];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int mcount(input int k);
    return (m_len[k] > 8) ? 8 : m_len[k];
  endfunction

  task automatic model_step(input int k);
    bit dup, hit;
    if (rst) begin
      m_state[k] = 0; m_len[k] = 0; m_lvld[k] = 0; p_rd[k] = 0;
      return;
    end
    p_rd[k] = rd_en;
    p_ok[k] = (int'(rd_idx) < mcount(k));
    if (p_ok[k]) p_dat[k] = hist[k][m_len[k] - mcount(k) + int'(rd_idx)];
    if (arm) begin
      m_state[k] = 1; m_len[k] = 0; m_lvld[k] = 0;
      return;
    end
`ifdef SERVANT_TRACE_DEDUP_EN
    dup = m_lvld[k] && (adr == m_last[k]);
`else
    dup = 1'b0;
`endif
    if ((m_state[k] == 1 || m_state[k] == 2) && vld && !dup) begin
      hit = (m_state[k] == 1) && trig_en && (adr == trig_adr);
      hist[k][m_len[k]] = adr;
      m_len[k]++;
      m_last[k] = adr;
      m_lvld[k] = 1;
      if (hit) begin
        m_trig[k]  = m_len[k] - 1;
        m_rem[k]   = post_of[k];
        m_state[k] = (post_of[k] == 0) ? 3 : 2;
      end else if (m_state[k] == 2) begin
        m_rem[k]--;
        if (m_rem[k] == 0) m_state[k] = 3;
      end
    end
  endtask

  task automatic compare(input int k);
    logic [1:0]  st;
    logic [3:0]  cnt;
    logic [2:0]  tix;
    logic        dn, rv;
    logic [31:0] rdat;
    string       tag;
    tag  = (k == 0) ? "a" : "b";
    st   = (k == 0) ? bus_a.o_state    : bus_b.o_state;
    cnt  = (k == 0) ? bus_a.o_count    : bus_b.o_count;
    tix  = (k == 0) ? bus_a.o_trig_idx : bus_b.o_trig_idx;
    dn   = (k == 0) ? bus_a.o_done     : bus_b.o_done;
    rv   = (k == 0) ? bus_a.o_rd_vld   : bus_b.o_rd_vld;
    rdat = (k == 0) ? bus_a.o_rd_dat   : bus_b.o_rd_dat;
    chk({tag, ".state"}, 32'(st), 32'(m_state[k]));
    chk({tag, ".done"}, 32'(dn), 32'(m_state[k] == 3));
    chk({tag, ".count"}, 32'(cnt), 32'(mcount(k)));
    chk({tag, ".rd_vld"}, 32'(rv), 32'(p_rd[k]));
    if (p_rd[k] && p_ok[k]) chk({tag, ".rd_dat"}, rdat, p_dat[k]);
    if (m_state[k] == 3)
      chk({tag, ".trig_idx"}, 32'(tix), 32'((m_trig[k] - (m_len[k] - mcount(k))) & 7));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    compare(0);
    compare(1);
  endtask

  task automatic idle();
    rst = 0; arm = 0; vld = 0; trig_en = 0; rd_en = 0;
    adr = '0; trig_adr = '0; rd_idx = '0;
  endtask

  task automatic do_arm();
    arm = 1; vld = 0; cyc(); arm = 0;
  endtask

  task automatic rd_a(input int idx, input logic [31:0] exp, input string name);
    rd_en = 1; rd_idx = 3'(idx); vld = 0; cyc(); rd_en = 0;
    chk(name, bus_a.o_rd_dat, exp);
  endtask

  initial begin
    post_of[0] = 2;
    post_of[1] = 0;
    idle();
    rst = 1; rd_en = 1; cyc(); rst = 0; rd_en = 0;
    chk("reset.state", 32'(bus_a.o_state), 32'd0);
    chk("reset.count", 32'(bus_a.o_count), 32'd0);
    chk("reset.rd_dat", bus_a.o_rd_dat, 32'd0);
    chk("reset.trig_idx", 32'(bus_a.o_trig_idx), 32'd0);

    // Trigger inside an unwrapped buffer.
    do_arm();
    trig_en = 1; trig_adr = 32'h10C;
    for (int i = 0; i < 8; i++) begin
      vld = 1; adr = 32'h100 + 32'(4 * i); cyc();
    end
    vld = 0;
    chk("t1.state", 32'(bus_a.o_state), 32'd3);
    chk("t1.count", 32'(bus_a.o_count), 32'd6);
    chk("t1.trig_idx", 32'(bus_a.o_trig_idx), 32'd3);
    rd_a(0, 32'h100, "t1.idx0");
    rd_a(5, 32'h114, "t1.idx5");

    // Wrapped buffer: trigger on the 10th sample, two more follow.
    do_arm();
    trig_en = 1; trig_adr = 32'h24;
    for (int i = 0; i < 12; i++) begin
      vld = 1; adr = 32'(4 * i); cyc();
    end
    vld = 0;
    chk("t2.state", 32'(bus_a.o_state), 32'd3);
    chk("t2.count", 32'(bus_a.o_count), 32'd8);
    chk("t2.trig_idx", 32'(bus_a.o_trig_idx), 32'd5);
    rd_a(0, 32'h10, "t2.idx0");

    // POST=0 instance stops on the trigger sample itself.
    do_arm();
    trig_en = 1; trig_adr = 32'h40; vld = 1; adr = 32'h40; cyc(); vld = 0;
    chk("t3.state", 32'(bus_b.o_state), 32'd3);
    chk("t3.count", 32'(bus_b.o_count), 32'd1);
    chk("t3.trig_idx", 32'(bus_b.o_trig_idx), 32'd0);

    // Re-arm during POST with a concurrent sample.
    do_arm();
    trig_en = 1; trig_adr = 32'h100; vld = 1; adr = 32'h100; cyc();
    chk("t4.post", 32'(bus_a.o_state), 32'd2);
    arm = 1; adr = 32'h104; cyc(); arm = 0;
    chk("t4.state", 32'(bus_a.o_state), 32'd1);
    chk("t4.count", 32'(bus_a.o_count), 32'd0);
    trig_en = 0; adr = 32'h108; cyc(); vld = 0;
    chk("t4.count1", 32'(bus_a.o_count), 32'd1);
    rd_a(0, 32'h108, "t4.idx0");

    // Repeated addresses.
    do_arm();
    trig_en = 0;
    vld = 1; adr = 32'h20; cyc(); cyc();
    adr = 32'h24; cyc(); cyc();
    adr = 32'h20; cyc(); vld = 0;
`ifdef SERVANT_TRACE_DEDUP_EN
    chk("t5.count", 32'(bus_a.o_count), 32'd3);
    rd_a(1, 32'h24, "t5.idx1");
    rd_a(2, 32'h20, "t5.idx2");
`else
    chk("t5.count", 32'(bus_a.o_count), 32'd5);
    rd_a(1, 32'h20, "t5.idx1");
    rd_a(2, 32'h24, "t5.idx2");
`endif

    // Reset during POST.
    do_arm();
    trig_en = 1; trig_adr = 32'h100; vld = 1; adr = 32'h100; cyc();
    rst = 1; rd_en = 1; adr = 32'h104; cyc(); rst = 0; rd_en = 0; vld = 0;
    chk("t6.state", 32'(bus_a.o_state), 32'd0);
    chk("t6.done", 32'(bus_a.o_done), 32'd0);
    chk("t6.count", 32'(bus_a.o_count), 32'd0);
    chk("t6.rd_vld", 32'(bus_a.o_rd_vld), 32'd0);

    // Randomized traffic over a small address set so triggers and repeats are frequent.
    for (int c = 0; c < 2500; c++) begin
      rst      = ($urandom_range(0, 299) == 0);
      arm      = ($urandom_range(0, 39) == 0);
      vld      = ($urandom_range(0, 9) < 7);
      adr      = 32'h100 + 32'(4 * $urandom_range(0, 5));
      trig_en  = ($urandom_range(0, 4) != 0);
      trig_adr = 32'h100 + 32'(4 * $urandom_range(0, 5));
      rd_en    = ($urandom_range(0, 9) < 6);
      rd_idx   = 3'($urandom_range(0, 7));
      cyc();
    end
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
